// File: rtl/bellek_hakem.sv
// rtl/bellek_hakem.sv - two-port arbiter in front of the single-port registered-read memory
module bellek_hakem #(
  parameter int                   ADRES_BIT       = 32,
  parameter int                   VERI_BIT        = 32,
  parameter int                   OKU_GECIKME     = 1,
  parameter int                   ONCELIK_MODU    = 0,
  parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i0_istek_gecerli,
  output logic                 i0_istek_hazir,
  input  logic [ADRES_BIT-1:0] i0_adres,
  input  logic [VERI_BIT-1:0]  i0_yaz_veri,
  input  logic                 i0_yaz,
  output logic                 i0_yanit_gecerli,
  output logic [VERI_BIT-1:0]  i0_yanit_veri,
  input  logic                 i1_istek_gecerli,
  output logic                 i1_istek_hazir,
  input  logic [ADRES_BIT-1:0] i1_adres,
  input  logic [VERI_BIT-1:0]  i1_yaz_veri,
  input  logic                 i1_yaz,
  output logic                 i1_yanit_gecerli,
  output logic [VERI_BIT-1:0]  i1_yanit_veri,
  output logic [ADRES_BIT-1:0] bellek_adres,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri,
  output logic                 mesgul,
  output logic                 sahip
);

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    ERISIM    = 2'd1,
    OKU_BEKLE = 2'd2,
    YANIT     = 2'd3
  } durum_t;

  durum_t              durum;
  durum_t              sonraki;
  logic                son_sahip;
  logic                yaz_r;
  logic [3:0]          sayac;
  logic                kazanan;
  logic                kabul;
  logic                yakala;
  logic [VERI_BIT-1:0] yakalanan;

  // State register; reset aborts whatever transfer is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      durum <= BOSTA;
    end else begin
      durum <= sonraki;
    end
  end

  // Arbitration, next state, handshake and strobe outputs.
  always_comb begin
    sonraki          = durum;
    i0_istek_hazir   = 1'b0;
    i1_istek_hazir   = 1'b0;
    bellek_yaz       = 1'b0;
    i0_yanit_gecerli = 1'b0;
    i1_yanit_gecerli = 1'b0;
    yakala           = 1'b0;
    yakalanan        = bellek_oku_veri;
    kabul            = 1'b0;
    kazanan          = 1'b0;
    mesgul           = (durum != BOSTA);

    // A lone requester always wins; on a tie either port 0 is preferred
    // or the port that did not own the previous transfer goes next.
    if (i0_istek_gecerli && i1_istek_gecerli) begin
      kazanan = (ONCELIK_MODU != 0) ? 1'b0 : ~son_sahip;
    end else begin
      kazanan = i1_istek_gecerli;
    end

    case (durum)
      BOSTA: begin
        if (!rst && (i0_istek_gecerli || i1_istek_gecerli)) begin
          i0_istek_hazir = ~kazanan;
          i1_istek_hazir = kazanan;
          kabul          = 1'b1;
          sonraki        = ERISIM;
        end
      end
      ERISIM: begin
        // The strobe is masked during reset so an aborted write never lands.
        bellek_yaz = yaz_r & ~rst;
        if (yaz_r) begin
          yakala    = 1'b1;
          yakalanan = '0;
          sonraki   = YANIT;
        end else if (OKU_GECIKME == 1) begin
          yakala  = 1'b1;
          sonraki = YANIT;
        end else begin
          sonraki = OKU_BEKLE;
        end
      end
      OKU_BEKLE: begin
        // The counter reaches zero at the edge ending this cycle: last wait cycle.
        if (sayac == 4'd1) begin
          yakala  = 1'b1;
          sonraki = YANIT;
        end
      end
      YANIT: begin
        i0_yanit_gecerli = ~sahip;
        i1_yanit_gecerli = sahip;
        sonraki          = BOSTA;
      end
      default: sonraki = BOSTA;
    endcase
  end

  // Request latch, read-wait counter, ownership and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bellek_adres    <= BASLANGIC_ADRES;
      bellek_yaz_veri <= '0;
      yaz_r           <= 1'b0;
      sayac           <= 4'd0;
      sahip           <= 1'b0;
      son_sahip       <= 1'b1;
      i0_yanit_veri   <= '0;
      i1_yanit_veri   <= '0;
    end else begin
      if (kabul) begin
        bellek_adres    <= kazanan ? i1_adres    : i0_adres;
        bellek_yaz_veri <= kazanan ? i1_yaz_veri : i0_yaz_veri;
        yaz_r           <= kazanan ? i1_yaz      : i0_yaz;
        sahip           <= kazanan;
        son_sahip       <= kazanan;
      end
      if (durum == ERISIM) begin
        sayac <= 4'(OKU_GECIKME - 1);
      end else if (durum == OKU_BEKLE) begin
        sayac <= sayac - 4'd1;
      end
      if (yakala) begin
        if (sahip) begin
          i1_yanit_veri <= yakalanan;
        end else begin
          i0_yanit_veri <= yakalanan;
        end
      end
    end
  end

endmodule
